// File: rtl/uart_tx_queue_if.sv
// Producer-side bundle for the buffered UART transmitter: push port plus
// queue/line status outputs.
interface uart_tx_queue_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              busy;
  logic              tx_done;
  logic              UART_TX;

  modport master (
    output wr_en, wr_data,
    input  full, count, overflow, busy, tx_done, UART_TX
  );

  modport slave (
    input  wr_en, wr_data,
    output full, count, overflow, busy, tx_done, UART_TX
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Buffered 8N1 UART transmitter: a DEPTH-byte FIFO drained onto UART_TX with
// an internal baud divider; back-to-back frames leave no idle gap.
module uart_tx_queue #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_queue_if.slave bus
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(DIV - 1);
  localparam logic [ADDR_W:0]  FULL_CNT  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt, cnt_n;
  logic              full_q, ovf_q;
  logic              push, pop;

  logic [CNT_W-1:0]  baud, baud_n;
  logic [2:0]        bit_idx, bit_n;
  logic [7:0]        shift, shift_n;
  logic              tx_q, tx_n;
  logic              done_q, done_n;

  // full is registered, so a pop on the same edge cannot rescue a push
  assign push = bus.wr_en && !full_q;

  always_comb begin
    cnt_n = cnt;
    if (push && !pop)
      cnt_n = cnt + (ADDR_W + 1)'(1);
    else if (pop && !push)
      cnt_n = cnt - (ADDR_W + 1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      cnt    <= cnt_n;
      full_q <= (cnt_n == FULL_CNT);
      if (bus.wr_en && full_q)
        ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.wr_data;
  end

  // Data bits leave from shift[0]; the register shifts right once per bit,
  // so the next bit to drive is always shift[1].
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx_q;
    done_n  = 1'b0;
    pop     = 1'b0;

    case (state)
      IDLE: begin
        if (cnt != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
          tx_n    = 1'b0;
          baud_n  = '0;
        end
      end

      START: begin
        if (baud == LAST_TICK) begin
          baud_n  = '0;
          state_n = DATA;
          bit_n   = '0;
          tx_n    = shift[0];
        end else begin
          baud_n  = baud + CNT_W'(1);
        end
      end

      DATA: begin
        if (baud == LAST_TICK) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_idx + 3'd1;
            tx_n    = shift[1];
            shift_n = {1'b1, shift[7:1]};
          end
        end else begin
          baud_n = baud + CNT_W'(1);
        end
      end

      STOP: begin
        if (baud == LAST_TICK) begin
          baud_n = '0;
          done_n = 1'b1;
          if (cnt != '0) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + CNT_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        baud_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx_q    <= tx_n;
      done_q  <= done_n;
    end
  end

  assign bus.full     = full_q;
  assign bus.count    = cnt;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state != IDLE);
  assign bus.tx_done  = done_q;
  assign bus.UART_TX  = tx_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: frame-level reference model compared every cycle,
// table-driven single frames, hand-timed corner sequences and random pushes.
module tb_uart_tx_queue;

  localparam int unsigned CLK_FREQ = 1600;
  localparam int unsigned BAUD     = 100;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned DIV      = CLK_FREQ / BAUD;
  localparam int unsigned FRAME    = 10 * DIV;

  logic clk;
  logic rst;

  uart_tx_queue_if #(.ADDR_W(ADDR_W)) bus();

  uart_tx_queue #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a byte queue plus the number of cycles left in the
  // current frame; line level is derived from the position inside the frame.
  logic [7:0] mq [$];
  int         rem;
  int         sz;
  logic [7:0] cur;
  logic       m_ovf;
  logic       m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      rem    = 0;
      m_ovf  = 1'b0;
      m_done = 1'b0;
      cur    = 8'h00;
    end else begin
      sz     = mq.size();
      m_done = 1'b0;
      if (rem != 0) begin
        rem--;
        if (rem == 0) m_done = 1'b1;
      end
      if (rem == 0 && sz != 0) begin
        cur = mq.pop_front();
        rem = FRAME;
      end
      if (bus.wr_en) begin
        if (sz < DEPTH) mq.push_back(bus.wr_data);
        else            m_ovf = 1'b1;
      end
    end
  end

  function automatic logic exp_line();
    int pos;
    int idx;
    if (rem == 0) return 1'b1;
    pos = FRAME - rem;
    idx = pos / DIV;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return cur[idx-1];
    return 1'b1;
  endfunction

  bit mon_en = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("m_count",    bus.count,    mq.size());
      check("m_full",     bus.full,     (mq.size() == DEPTH));
      check("m_overflow", bus.overflow, m_ovf);
      check("m_busy",     bus.busy,     (rem != 0));
      check("m_tx_done",  bus.tx_done,  m_done);
      check("m_line",     bus.UART_TX,  exp_line());
    end
  end

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n, output logic ok);
    n  = 0;
    ok = 1'b0;
    while (n < limit && !ok) begin
      @(negedge clk);
      n++;
      if (bus.tx_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int limit, output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < limit && !ok) begin
      @(negedge clk);
      n++;
      if (bus.busy === 1'b0 && bus.count === '0) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // bit k = line level during bit period k
  } vec_t;

  vec_t vecs [5];

  initial begin
    int   n;
    logic ok;
    int   thresh;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h55, 10'b1010101010};

    clk = 1'b0;
    rst = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    thresh = 10;

    // Reset before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_line",     bus.UART_TX,  1);
    check("rst_count",    bus.count,    0);
    check("rst_busy",     bus.busy,     0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_full",     bus.full,     0);
    check("rst_tx_done",  bus.tx_done,  0);
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1;

    // Single frames from the table
    for (int v = 0; v < 5; v++) begin
      push_byte(vecs[v].data);
      check($sformatf("vec%0d_count1", v), bus.count, 1);
      @(negedge clk);
      check($sformatf("vec%0d_start", v), bus.UART_TX, 0);
      check($sformatf("vec%0d_busy", v), bus.busy, 1);
      repeat (DIV / 2) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        check($sformatf("vec%0d_bit%0d", v, k), bus.UART_TX, vecs[v].line[k]);
        if (k < 9) repeat (DIV) @(negedge clk);
      end
      repeat (DIV / 2 - 1) @(negedge clk);
      check($sformatf("vec%0d_done_early", v), bus.tx_done, 0);
      check($sformatf("vec%0d_busy_stop", v), bus.busy, 1);
      @(negedge clk);
      check($sformatf("vec%0d_done", v), bus.tx_done, 1);
      check($sformatf("vec%0d_busy_end", v), bus.busy, 0);
      check($sformatf("vec%0d_count_end", v), bus.count, 0);
      check($sformatf("vec%0d_idle_line", v), bus.UART_TX, 1);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", v), bus.tx_done, 0);
    end

    // Back-to-back frames
    @(negedge clk); bus.wr_en = 1'b1; bus.wr_data = 8'h00;
    @(negedge clk); bus.wr_data = 8'hFF;
    @(negedge clk); bus.wr_data = 8'h3C;
    @(negedge clk); bus.wr_en = 1'b0;
    wait_done(FRAME + 20, n, ok);
    check("b2b_done1_seen", ok, 1);
    check("b2b_start2", bus.UART_TX, 0);
    check("b2b_busy2", bus.busy, 1);
    wait_done(FRAME + 20, n, ok);
    check("b2b_gap1", n, FRAME);
    check("b2b_start3", bus.UART_TX, 0);
    wait_done(FRAME + 20, n, ok);
    check("b2b_gap2", n, FRAME);
    check("b2b_idle_busy", bus.busy, 0);
    check("b2b_idle_line", bus.UART_TX, 1);

    // Fill to full while a frame is in flight, then overflow
    push_byte(8'h11);
    repeat (4) @(negedge clk);
    check("ovf_inflight_busy", bus.busy, 1);
    check("ovf_inflight_count", bus.count, 0);
    bus.wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wr_data = 8'(8'h21 + i);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    check("ovf_count", bus.count, DEPTH);
    check("ovf_full", bus.full, 1);
    check("ovf_flag", bus.overflow, 1);
    wait_idle(6 * FRAME + 50, ok);
    check("ovf_drain", ok, 1);
    check("ovf_sticky", bus.overflow, 1);
    check("ovf_full_clear", bus.full, 0);

    // Reset during data bit 3 of 0x55 with two bytes queued
    push_byte(8'h55);
    @(negedge clk);
    check("mid_start", bus.UART_TX, 0);
    repeat (4) @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_data = 8'h66;
    @(negedge clk); bus.wr_data = 8'h77;
    @(negedge clk); bus.wr_en = 1'b0;
    check("mid_count2", bus.count, 2);
    repeat (4 * DIV + DIV / 2 - 6) @(negedge clk);
    check("mid_bit3", bus.UART_TX, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_line", bus.UART_TX, 1);
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_overflow", bus.overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("mid_after_line", bus.UART_TX, 1);
    check("mid_after_busy", bus.busy, 0);
    check("mid_after_count", bus.count, 0);

    // Push on the STOP-to-START pop edge with two bytes queued
    push_byte(8'h81);
    @(negedge clk);
    check("pp_start", bus.UART_TX, 0);
    repeat (4) @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_data = 8'h42;
    @(negedge clk); bus.wr_data = 8'h24;
    @(negedge clk); bus.wr_en = 1'b0;
    repeat (FRAME - 7) @(negedge clk);
    check("pp_count_before", bus.count, 2);
    check("pp_done_before", bus.tx_done, 0);
    bus.wr_en = 1'b1; bus.wr_data = 8'h99;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("pp_count_after", bus.count, 2);
    check("pp_done", bus.tx_done, 1);
    check("pp_next_start", bus.UART_TX, 0);
    wait_idle(4 * FRAME + 50, ok);
    check("pp_drain", ok, 1);

    // Random pushes against the model, with one asynchronous reset
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) thresh = $urandom_range(2, 40);
      @(negedge clk);
      if (c == 2101) rst = 1'b0;
      bus.wr_en   = ($urandom_range(0, 999) < thresh);
      bus.wr_data = 8'($urandom);
      if (c == 2100) begin
        #($urandom_range(1, 4));
        rst = 1'b1;
      end
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    wait_idle(6 * FRAME + 50, ok);
    check("rnd_drain", ok, 1);
    check("rnd_idle_line", bus.UART_TX, 1);

    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
